// File: rtl/seg_scanner_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Includes the parameter-legality check used at elaboration.
package seg_scanner_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [3:0] DIM_FULL = 4'hF;

    function automatic bit params_ok(
        input int nd,
        input int sw,
        input int div,
        input int blk
    );
        return (nd >= 2) && (nd <= 16) && (sw >= 1) &&
               (blk >= 1) && (blk < div);
    endfunction

endpackage

// File: rtl/seg_slot_counter.sv
// Slot counter and digit index for the scanner, plus the frame-start
// condition. Outputs are the values the counters take on the coming edge.
module seg_slot_counter #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1000,
    localparam int CW        = $clog2(SCAN_DIV),
    localparam int DW        = $clog2(NUM_DIGITS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt_nxt,
    output logic [DW-1:0] o_dig_nxt,
    output logic          o_frame_nxt
);

    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_dig;
    logic          r_run;

    logic [CW-1:0] w_cnt_nxt;
    logic [DW-1:0] w_dig_nxt;
    logic          w_frame_nxt;

    // A stopped scan always restarts at slot 0, count 0.
    always_comb begin
        w_cnt_nxt   = '0;
        w_dig_nxt   = '0;
        w_frame_nxt = 1'b0;
        if (!i_rst && i_en) begin
            if (r_run) begin
                if (r_cnt == CW'(SCAN_DIV - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_dig == DW'(NUM_DIGITS - 1)) begin
                        w_dig_nxt = '0;
                    end else begin
                        w_dig_nxt = r_dig + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_dig_nxt = r_dig;
                end
            end
            w_frame_nxt = (w_cnt_nxt == '0) && (w_dig_nxt == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_dig <= '0;
            r_run <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_dig <= w_dig_nxt;
            r_run <= i_en;
        end
    end

    assign o_cnt_nxt   = w_cnt_nxt;
    assign o_dig_nxt   = w_dig_nxt;
    assign o_frame_nxt = w_frame_nxt;

endmodule

// File: rtl/seg_scanner.sv
// Multiplexed segment-display scanner with shadowed frame data.
// Define SEG_SCANNER_DIM_EN to add the DIM brightness input.
module seg_scanner
    import seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SEG_W      = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 16,
    parameter int SEG_POL    = 1,
    parameter int SEL_POL    = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        EN,
    input  logic [NUM_DIGITS*SEG_W-1:0] SEG_IN,
`ifdef SEG_SCANNER_DIM_EN
    input  logic [3:0]                  DIM,
`endif
    output logic [SEG_W-1:0]            SEG_OUT,
    output logic [NUM_DIGITS-1:0]       SEG_SEL,
    output logic                        FRAME
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(NUM_DIGITS);

    localparam logic [SEG_W-1:0] SEG_INV =
        (SEG_POL != 0) ? '0 : '1;
    localparam logic [NUM_DIGITS-1:0] SEL_INV =
        (SEL_POL != 0) ? '0 : '1;

    if (!params_ok(NUM_DIGITS, SEG_W, SCAN_DIV, BLANK_CYC)) begin : g_bad
        $error("seg_scanner: illegal parameter combination");
    end

    logic [CW-1:0] w_cnt_nxt;
    logic [DW-1:0] w_dig_nxt;
    logic          w_frame_nxt;
    logic          w_run;
    logic          w_dim_on;

    scan_state_t r_state;
    scan_state_t w_state_nxt;

    logic [NUM_DIGITS*SEG_W-1:0] r_shadow;
    logic [SEG_W-1:0]            w_seg_act;
    logic [NUM_DIGITS-1:0]       w_sel_act;
    logic [SEG_W-1:0]            r_seg_out;
    logic [NUM_DIGITS-1:0]       r_seg_sel;
    logic                        r_frame;

    seg_slot_counter #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_slot (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_en        (EN),
        .o_cnt_nxt   (w_cnt_nxt),
        .o_dig_nxt   (w_dig_nxt),
        .o_frame_nxt (w_frame_nxt)
    );

    assign w_run = !RST && EN;

    // DRIVE is only entered at the end of blanking, so a select
    // change always passes through a blank interval.
    always_comb begin
        w_state_nxt = ST_BLANK;
        unique case (r_state)
            ST_BLANK: begin
                if (w_run && (32'(w_cnt_nxt) == BLANK_CYC)) begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (w_run && (w_cnt_nxt != '0)) begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            default: w_state_nxt = ST_BLANK;
        endcase
    end

`ifdef SEG_SCANNER_DIM_EN
    logic [3:0] w_phase;
    assign w_phase  = 4'(32'(w_cnt_nxt) - 32'(BLANK_CYC));
    assign w_dim_on = (DIM == DIM_FULL) || (w_phase < DIM);
`else
    assign w_dim_on = 1'b1;
`endif

    always_comb begin
        w_seg_act = '0;
        w_sel_act = '0;
        if ((w_state_nxt == ST_DRIVE) && w_dim_on) begin
            w_seg_act            = r_shadow[w_dig_nxt*SEG_W +: SEG_W];
            w_sel_act[w_dig_nxt] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_BLANK;
            r_shadow  <= '0;
            r_frame   <= 1'b0;
            r_seg_out <= SEG_INV;
            r_seg_sel <= SEL_INV;
        end else begin
            r_state <= w_state_nxt;
            if (w_frame_nxt) begin
                r_shadow <= SEG_IN;
            end
            r_frame   <= w_frame_nxt;
            r_seg_out <= w_seg_act ^ SEG_INV;
            r_seg_sel <= w_sel_act ^ SEL_INV;
        end
    end

    assign SEG_OUT = r_seg_out;
    assign SEG_SEL = r_seg_sel;
    assign FRAME   = r_frame;

endmodule

// File: tb/tb_seg_scanner.sv
// Scoreboard bench for seg_scanner: a time-based frame model predicts
// every cycle for an active-high and an active-low instance.
module tb_seg_scanner;

    localparam int ND = 4;
    localparam int SW = 8;
`ifdef SEG_SCANNER_DIM_EN
    localparam int DIV = 40;
    localparam int BLK = 8;
`else
    localparam int DIV = 8;
    localparam int BLK = 2;
`endif
    localparam int FRM = ND * DIV;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic           r_rst;
    logic           r_en;
    logic [ND*SW-1:0] r_seg_in;
    logic [3:0]     r_dim;

    logic [SW-1:0]  w_seg;
    logic [ND-1:0]  w_sel;
    logic           w_frame;
    logic [SW-1:0]  w_seg_n;
    logic [ND-1:0]  w_sel_n;
    logic           w_frame_n;

    seg_scanner #(
        .NUM_DIGITS (ND),
        .SEG_W      (SW),
        .SCAN_DIV   (DIV),
        .BLANK_CYC  (BLK),
        .SEG_POL    (1),
        .SEL_POL    (1)
    ) dut (
        .CLK     (CLK),
        .RST     (r_rst),
        .EN      (r_en),
        .SEG_IN  (r_seg_in),
`ifdef SEG_SCANNER_DIM_EN
        .DIM     (r_dim),
`endif
        .SEG_OUT (w_seg),
        .SEG_SEL (w_sel),
        .FRAME   (w_frame)
    );

    seg_scanner #(
        .NUM_DIGITS (ND),
        .SEG_W      (SW),
        .SCAN_DIV   (DIV),
        .BLANK_CYC  (BLK),
        .SEG_POL    (0),
        .SEL_POL    (0)
    ) dut_n (
        .CLK     (CLK),
        .RST     (r_rst),
        .EN      (r_en),
        .SEG_IN  (r_seg_in),
`ifdef SEG_SCANNER_DIM_EN
        .DIM     (r_dim),
`endif
        .SEG_OUT (w_seg_n),
        .SEG_SEL (w_sel_n),
        .FRAME   (w_frame_n)
    );

    typedef struct packed {
        logic [SW-1:0] seg;
        logic [ND-1:0] sel;
        logic          frame;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit               m_run    = 1'b0;
    int               m_t      = 0;
    logic [ND*SW-1:0] m_shadow = '0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    // Model: position in the frame is one integer t; slot and count
    // follow from division, lit state from the blank/dim rules.
    always @(posedge CLK) begin
        exp_t             e;
        int               t;
        int               c;
        int               d;
        bit               on;
        logic [ND*SW-1:0] sh;
        e  = '0;
        sh = m_shadow;
        cyc <= cyc + 1;
        if (r_rst) begin
            m_run    <= 1'b0;
            m_shadow <= '0;
        end else if (!r_en) begin
            m_run <= 1'b0;
        end else begin
            t  = m_run ? (m_t + 1) % FRM : 0;
            c  = t % DIV;
            d  = t / DIV;
            on = (c >= BLK) &&
                 ((r_dim == 4'hF) || (((c - BLK) % 16) < int'(r_dim)));
            e.frame = (t == 0);
            if (on) begin
                e.seg    = sh[d*SW +: SW];
                e.sel[d] = 1'b1;
            end
            m_run <= 1'b1;
            m_t   <= t;
            if (t == 0) m_shadow <= r_seg_in;
        end
        q.push_back(e);
    end

    always @(negedge CLK) begin
        exp_t          e;
        logic [SW-1:0] seg_inv;
        logic [ND-1:0] sel_inv;
        if (q.size() != 0) begin
            e       = q.pop_front();
            seg_inv = ~e.seg;
            sel_inv = ~e.sel;
            chk("seg",     32'(w_seg),     32'(e.seg));
            chk("sel",     32'(w_sel),     32'(e.sel));
            chk("frame",   32'(w_frame),   32'(e.frame));
            chk("seg_n",   32'(w_seg_n),   32'(seg_inv));
            chk("sel_n",   32'(w_sel_n),   32'(sel_inv));
            chk("frame_n", 32'(w_frame_n), 32'(e.frame));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_until(input int target);
        for (int k = 0; k < 4 * FRM; k++) begin
            if (m_run && (m_t == target)) return;
            step();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL run_until t=%0d got=timeout want=reached", target);
    endtask

    initial begin
        r_rst    = 1'b1;
        r_en     = 1'b1;
        r_seg_in = 32'h11223344;
        r_dim    = 4'hF;
        repeat (3) step();

        r_rst = 1'b0;
        repeat (2 * FRM) step();

        run_until(2 * DIV + 3);
        r_seg_in = 32'hAABBCCDD;
        repeat (FRM + DIV) step();

        run_until(DIV + 3);
        r_en = 1'b0;
        repeat (5) step();
        r_en = 1'b1;
        repeat (FRM) step();

        run_until(3 * DIV + BLK + 1);
        r_rst = 1'b1;
        repeat (2) step();
        r_rst = 1'b0;
        repeat (FRM) step();

`ifdef SEG_SCANNER_DIM_EN
        r_dim = 4'd4;
        repeat (FRM) step();
        r_dim = 4'hF;
        repeat (FRM) step();
        r_dim = 4'd0;
        repeat (FRM) step();
`endif

        repeat (1500) begin
            r_en  = ($urandom_range(0, 40) != 0);
            r_rst = ($urandom_range(0, 200) == 0);
            if ($urandom_range(0, 15) == 0) r_seg_in = $urandom;
`ifdef SEG_SCANNER_DIM_EN
            if ($urandom_range(0, 31) == 0) r_dim = 4'($urandom_range(0, 15));
`endif
            step();
        end

        r_rst = 1'b0;
        r_en  = 1'b0;
        repeat (2) step();
        @(negedge CLK);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
